// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
//   Single-clock synchronous FIFO with two read styles:
//     FWFT=0 : registered read. dout is loaded on an accepted pop and
//              dout_valid pulses for the following cycle.
//     FWFT=1 : first-word-fall-through. The head word is presented on dout
//              while the FIFO is non-empty, and rd_en acknowledges it.
//   Level and all status flags are registered. They reflect an accepted
//   operation from the cycle after the accepting edge.
//
// Parameters
//   WIDTH      data word width in bits
//   DEPTH      capacity in words (power of two, >= 4)
//   FWFT       0 = registered read, 1 = first-word-fall-through
//   AF_THRESH  almost_full when level >= AF_THRESH   (1..DEPTH)
//   AE_THRESH  almost_empty when level <= AE_THRESH  (0..DEPTH-1)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          write data
//   wr_en        write request
//   rd_en        read request (pop)
//   flush        synchronous clear of contents and error flags
//   dout         read data
//   dout_valid   dout holds a valid word
//   full/empty   level == DEPTH / level == 0
//   almost_full  level >= AF_THRESH
//   almost_empty level <= AE_THRESH
//   level        number of stored words, 0..DEPTH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
// ---------------------------------------------------------------------------
module sample_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 256,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("sample_fifo: WIDTH must be >= 1");
        end
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sample_fifo: DEPTH must be a power of two >= 4");
        end
        if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
            $error("sample_fifo: FWFT must be 0 or 1");
        end
        if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
            $error("sample_fifo: AF_THRESH must be in 1..DEPTH");
        end
        if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
            $error("sample_fifo: AE_THRESH must be in 0..DEPTH-1");
        end
    endgenerate

    localparam logic [ADDR_WIDTH:0] LVL_FULL = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LVL_AF   = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] LVL_AE   = AE_THRESH[ADDR_WIDTH:0];

    // -----------------------------------------------------------------------
    // Storage and state
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_level_next;

    // A write is refused when full even if a pop is accepted in the same
    // cycle, so acceptance looks only at the registered flags.
    assign w_wr_acc = wr_en & ~r_full  & ~flush;
    assign w_rd_acc = rd_en & ~r_empty & ~flush;

    always_comb begin
        w_level_next = r_level;
        if (flush) begin
            w_level_next = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_level_next = r_level + (ADDR_WIDTH + 1)'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_level_next = r_level - (ADDR_WIDTH + 1)'(1);
        end
    end

    // Memory array has no reset, so it can map onto block RAM. Stale words
    // left behind by reset or flush are unreachable because the pointers restart.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_wr_acc) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                end
                if (w_rd_acc) begin
                    r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
                end
                if (wr_en && r_full) begin
                    r_overflow <= 1'b1;
                end
                if (rd_en && r_empty) begin
                    r_underflow <= 1'b1;
                end
            end
            r_level        <= w_level_next;
            r_full         <= (w_level_next == LVL_FULL);
            r_empty        <= (w_level_next == '0);
            r_almost_full  <= (w_level_next >= LVL_AF);
            r_almost_empty <= (w_level_next <= LVL_AE);
        end
    end

    // -----------------------------------------------------------------------
    // Read-side presentation
    // -----------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // While empty the slot at rd_ptr holds no stored word. Presenting
            // 0 keeps the reset and flush values identical to registered mode.
            assign dout       = r_empty ? '0 : r_mem[r_rd_ptr];
            assign dout_valid = ~r_empty;
        end else begin : g_std
            logic [WIDTH-1:0] r_dout;
            logic             r_dout_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else if (flush) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_dout <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end
    endgenerate

    assign level        = r_level;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
